// File: rtl/ctrlbus_arbiter.sv
// ctrlbus_arbiter: shares one single-cycle emulator control bus between
// S_COUNT requesters. Each requester issues one read or write over a
// valid/ready request channel and receives one response over a valid/ready
// response channel. Only one transaction is in flight at a time.
// Optional feature macro: CTRLBUS_ARB_RR_EN selects round-robin arbitration;
// when undefined the lowest requesting index always wins.
module ctrlbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int S_COUNT    = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [S_COUNT-1:0]             s_req_valid,
    output logic [S_COUNT-1:0]             s_req_ready,
    input  logic [S_COUNT-1:0]             s_req_write,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_req_addr,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_req_wdata,
    output logic [S_COUNT-1:0]             s_resp_valid,
    input  logic [S_COUNT-1:0]             s_resp_ready,
    output logic [DATA_WIDTH-1:0]          s_resp_rdata,
    output logic                           m_ctrl_wen,
    output logic [ADDR_WIDTH-1:0]          m_ctrl_waddr,
    output logic [DATA_WIDTH-1:0]          m_ctrl_wdata,
    output logic                           m_ctrl_ren,
    output logic [ADDR_WIDTH-1:0]          m_ctrl_raddr,
    input  logic [DATA_WIDTH-1:0]          m_ctrl_rdata
);

    localparam int PTR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PTR_W-1:0]        r_own;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_nxt;
    logic [PTR_W-1:0]        w_win;
    logic                    w_found;
    logic                    w_hit;
    logic [S_COUNT-1:0]      w_req_ready;
    logic [S_COUNT-1:0]      w_own_onehot;
    logic                    w_accept;
    logic                    w_resp_done;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    logic                    r_wen;
    logic                    r_ren;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_resp;
    logic [S_COUNT-1:0]      r_resp_valid;

    // Rotating winner search: indices at or after ptr first, then wrap to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = {PTR_W{1'b0}};
        w_hit   = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            w_hit   = !w_found && s_req_valid[i] && (PTR_W'(i) >= r_ptr);
            w_win   = w_hit ? PTR_W'(i) : w_win;
            w_found = w_found | w_hit;
        end
        for (int i = 0; i < S_COUNT; i++) begin
            w_hit   = !w_found && s_req_valid[i];
            w_win   = w_hit ? PTR_W'(i) : w_win;
            w_found = w_found | w_hit;
        end
    end

    // Grant decode (IDLE only, never during reset) and winner field mux.
    always_comb begin
        w_req_ready = {S_COUNT{1'b0}};
        w_sel_write = 1'b0;
        w_sel_addr  = {ADDR_WIDTH{1'b0}};
        w_sel_wdata = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < S_COUNT; i++) begin
            w_req_ready[i] = resetn && (r_state == ST_IDLE) && w_found &&
                             (w_win == PTR_W'(i));
            w_sel_write = (w_win == PTR_W'(i)) ? s_req_write[i] : w_sel_write;
            w_sel_addr  = (w_win == PTR_W'(i)) ?
                          s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : w_sel_addr;
            w_sel_wdata = (w_win == PTR_W'(i)) ?
                          s_req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_wdata;
        end
    end

    // One-hot of the current owner, used to raise its response valid.
    always_comb begin
        w_own_onehot = {S_COUNT{1'b0}};
        for (int i = 0; i < S_COUNT; i++) begin
            w_own_onehot[i] = (r_own == PTR_W'(i));
        end
    end

    assign w_accept    = |w_req_ready;
    assign w_resp_done = (r_state == ST_RESP) && s_resp_ready[r_own];

    // Next-state logic: accept -> one bus cycle -> wait for response consume.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Priority pointer: advances past the owner on completion in round-robin
    // mode, pinned to 0 in fixed-priority mode.
    always_comb begin
        w_ptr_nxt = r_ptr;
`ifdef CTRLBUS_ARB_RR_EN
        if (w_resp_done) begin
            w_ptr_nxt = (r_own == PTR_W'(S_COUNT - 1)) ? {PTR_W{1'b0}}
                                                      : (r_own + PTR_W'(1));
        end else begin
            w_ptr_nxt = r_ptr;
        end
`else
        w_ptr_nxt = {PTR_W{1'b0}};
`endif
    end

    // State, owner and pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= {PTR_W{1'b0}};
            r_own   <= {PTR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_accept) begin
                r_own <= w_win;
            end else begin
                r_own <= r_own;
            end
        end
    end

    // Bus-side registers: strobes live only in ISSUE; addresses/data hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_waddr <= {ADDR_WIDTH{1'b0}};
            r_raddr <= {ADDR_WIDTH{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_wen <= w_accept && w_sel_write;
            r_ren <= w_accept && !w_sel_write;
            if (w_accept && w_sel_write) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end else begin
                r_waddr <= r_waddr;
                r_wdata <= r_wdata;
            end
            if (w_accept && !w_sel_write) begin
                r_raddr <= w_sel_addr;
            end else begin
                r_raddr <= r_raddr;
            end
        end
    end

    // Response registers: read data captured at the end of the bus cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp       <= {DATA_WIDTH{1'b0}};
            r_resp_valid <= {S_COUNT{1'b0}};
        end else begin
            if (r_state == ST_ISSUE) begin
                r_resp       <= r_ren ? m_ctrl_rdata : {DATA_WIDTH{1'b0}};
                r_resp_valid <= w_own_onehot;
            end else if (w_resp_done) begin
                r_resp       <= r_resp;
                r_resp_valid <= {S_COUNT{1'b0}};
            end else begin
                r_resp       <= r_resp;
                r_resp_valid <= r_resp_valid;
            end
        end
    end

    assign s_req_ready  = w_req_ready;
    assign s_resp_valid = r_resp_valid;
    assign s_resp_rdata = r_resp;
    assign m_ctrl_wen   = r_wen;
    assign m_ctrl_ren   = r_ren;
    assign m_ctrl_waddr = r_waddr;
    assign m_ctrl_wdata = r_wdata;
    assign m_ctrl_raddr = r_raddr;

endmodule

// File: tb/tb_ctrlbus_arbiter.sv
// Scoreboard bench for ctrlbus_arbiter: the driver pushes expected bus cycles
// and responses into queues; independent monitors pop and compare them.
// Directed checks cover reset, latency, contention, back-pressure and wrap.
module tb_ctrlbus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT, S_COUNT = 2
    logic [1:0]  req_valid, req_write, req_ready, resp_valid, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] resp_rdata, m_waddr, m_wdata, m_raddr, m_rdata;
    logic        m_wen, m_ren;

    // second DUT, S_COUNT = 3 (wrap-around)
    logic [2:0]  v3, w3, rdy3, rv3;
    logic [2:0]  rr3 = 3'b111;
    logic [95:0] a3, d3;
    logic [31:0] rd3, waddr3, wdata3, raddr3, rdata3;
    logic        wen3, ren3;

    function automatic logic [31:0] bus_model(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234 : (a ^ 32'hDEAD_0000);
    endfunction

    assign m_rdata = m_ren ? bus_model(m_raddr) : 32'hFFFF_FFFF;
    assign rdata3  = ren3  ? bus_model(raddr3)  : 32'hFFFF_FFFF;

    ctrlbus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .S_COUNT(2)) dut (
        .clk(clk), .resetn(resetn),
        .s_req_valid(req_valid), .s_req_ready(req_ready), .s_req_write(req_write),
        .s_req_addr(req_addr), .s_req_wdata(req_wdata),
        .s_resp_valid(resp_valid), .s_resp_ready(resp_ready), .s_resp_rdata(resp_rdata),
        .m_ctrl_wen(m_wen), .m_ctrl_waddr(m_waddr), .m_ctrl_wdata(m_wdata),
        .m_ctrl_ren(m_ren), .m_ctrl_raddr(m_raddr), .m_ctrl_rdata(m_rdata)
    );

    ctrlbus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .S_COUNT(3)) dut3 (
        .clk(clk), .resetn(resetn),
        .s_req_valid(v3), .s_req_ready(rdy3), .s_req_write(w3),
        .s_req_addr(a3), .s_req_wdata(d3),
        .s_resp_valid(rv3), .s_resp_ready(rr3), .s_resp_rdata(rd3),
        .m_ctrl_wen(wen3), .m_ctrl_waddr(waddr3), .m_ctrl_wdata(wdata3),
        .m_ctrl_ren(ren3), .m_ctrl_raddr(raddr3), .m_ctrl_rdata(rdata3)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { int id; logic [31:0] data; } resp_t;
    bus_t  bus_q[$];
    resp_t resp_q[$];

    int total = 0;
    int bad = 0;
    int last_strobe_cyc = 0;
    int last_resp_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bus monitor: every strobe must match the head of the expected bus queue
    always @(negedge clk) begin : mon_bus
        bus_t e;
        if (resetn && (m_wen || m_ren)) begin
            check("bus_strobe_excl", 64'(m_wen & m_ren), 64'd0);
            check("bus_expected", 64'(bus_q.size() > 0), 64'd1);
            if (bus_q.size() > 0) begin
                e = bus_q.pop_front();
                check("bus_wen", 64'(m_wen), 64'(e.wr));
                check("bus_addr", 64'(m_wen ? m_waddr : m_raddr), 64'(e.addr));
                if (m_wen) check("bus_wdata", 64'(m_wdata), 64'(e.data));
            end
            last_strobe_cyc = cyc;
        end
    end

    // response monitor: every completed response must match the queue head
    always @(negedge clk) begin : mon_resp
        resp_t e;
        if (resetn) begin
            if (|req_ready) check("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
            if (|resp_valid) check("resp_valid_onehot", 64'($countones(resp_valid)), 64'd1);
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
                    if (resp_q.size() > 0) begin
                        e = resp_q.pop_front();
                        check("resp_id", 64'(i), 64'(e.id));
                        check("resp_rdata", 64'(resp_rdata), 64'(e.data));
                    end
                    last_resp_cyc = cyc;
                end
            end
        end
    end

    task automatic set_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*32 +: 32] = a;
        req_wdata[id*32 +: 32] = d;
    endtask

    task automatic expect_txn(input int id, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] r);
        bus_q.push_back('{wr: wr, addr: a, data: d});
        resp_q.push_back('{id: id, data: r});
    endtask

    // waits (bounded) for s_req_ready[id], records its cycle, drops valid after accept
    task automatic wait_grant(input int id, output int t);
        bit got;
        got = 1'b0;
        t = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                t = cyc;
            end
        end
        check("grant_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    // waits (bounded) for any grant, valids untouched
    task automatic wait_any_grant(output int g, output int t);
        bit got;
        got = 1'b0;
        g = -1;
        t = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (|req_ready) begin
                got = 1'b1;
                g = req_ready[1] ? 1 : 0;
                t = cyc;
            end
        end
        check("any_grant_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (bus_q.size() + resp_q.size()) > 0; k++) @(negedge clk);
        check("queues_drained", 64'(bus_q.size() + resp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t0, t1, g, tprev;
        int exp_g[4];
        req_valid = 2'b11; req_write = 2'b11;
        req_addr = 64'h0000_0010_0000_0020; req_wdata = 64'h0;
        resp_ready = 2'b11;
        v3 = 3'b000; w3 = 3'b000; a3 = 96'h0; d3 = 96'h0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_wen", 64'(m_wen), 64'd0);
        check("rst_ren", 64'(m_ren), 64'd0);
        check("rst_waddr", 64'(m_waddr), 64'd0);
        check("rst_wdata", 64'(m_wdata), 64'd0);
        check("rst_raddr", 64'(m_raddr), 64'd0);
        check("rst_rdata", 64'(resp_rdata), 64'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        resetn = 1'b1;
        @(posedge clk); #1;

        // single write from requester 0
        set_req(0, 1'b1, 32'h10, 32'hA5A5);
        expect_txn(0, 1'b1, 32'h10, 32'hA5A5, 32'h0);
        wait_grant(0, t);
        drain();
        check("wr_strobe_latency", 64'(last_strobe_cyc - t), 64'd1);
        check("wr_resp_latency", 64'(last_resp_cyc - t), 64'd2);

        // single read from requester 1
        set_req(1, 1'b0, 32'h20, 32'h0);
        expect_txn(1, 1'b0, 32'h20, 32'h0, 32'h1234);
        wait_grant(1, t);
        drain();
        check("rd_strobe_latency", 64'(last_strobe_cyc - t), 64'd1);
        check("rd_resp_latency", 64'(last_resp_cyc - t), 64'd2);

        // contention: both valid continuously for four grants
`ifdef CTRLBUS_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            if (exp_g[k] == 0) expect_txn(0, 1'b1, 32'h100, 32'h11, 32'h0);
            else               expect_txn(1, 1'b1, 32'h200, 32'h22, 32'h0);
        end
        set_req(0, 1'b1, 32'h100, 32'h11);
        set_req(1, 1'b1, 32'h200, 32'h22);
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any_grant(g, t);
            check("grant_order", 64'(g), 64'(exp_g[k]));
            if (k > 0) check("grant_spacing", 64'(t - tprev), 64'd3);
            tprev = t;
        end
        req_valid = 2'b00;
        drain();

        // response back-pressure for several cycles
        resp_ready = 2'b00;
        set_req(1, 1'b0, 32'h40, 32'h0);
        expect_txn(1, 1'b0, 32'h40, 32'h0, 32'hDEAD_0040);
        wait_grant(1, t);
        set_req(0, 1'b1, 32'h50, 32'h99);
        expect_txn(0, 1'b1, 32'h50, 32'h99, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(resp_valid), 64'd2);
            check("bp_resp_rdata", 64'(resp_rdata), 64'hDEAD_0040);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_no_strobe", 64'({m_wen, m_ren}), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 2'b11;
        wait_grant(0, t);
        drain();

        // reset during the strobe cycle
        set_req(0, 1'b1, 32'h300, 32'h77);
        wait_grant(0, t);
        check("issue_wen_before_rst", 64'(m_wen), 64'd1);
        set_req(0, 1'b0, 32'h44, 32'h0);
        set_req(1, 1'b0, 32'h48, 32'h0);
        resetn = 1'b0;
        #1;
        check("midrst_wen", 64'(m_wen), 64'd0);
        check("midrst_ren", 64'(m_ren), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_ptr", 64'(dut.r_ptr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_txn(0, 1'b0, 32'h44, 32'h0, 32'hDEAD_0044);
        expect_txn(1, 1'b0, 32'h48, 32'h0, 32'hDEAD_0048);
        resetn = 1'b1;
        wait_grant(0, t0);
        wait_grant(1, t1);
        drain();
        check("postrst_spacing", 64'(t1 - t0), 64'd3);
        check("postrst_resp_latency", 64'(last_resp_cyc - t1), 64'd2);

        // S_COUNT = 3: requester 1 completes, then 0 and 1 contend -> 0 wins
        v3 = 3'b010; w3 = 3'b000; a3[63:32] = 32'h20;
        @(negedge clk);
        check("s3_first_ready", 64'(rdy3), 64'd2);
        @(posedge clk); #1;
        v3 = 3'b000;
        @(negedge clk);
        check("s3_ren", 64'(ren3), 64'd1);
        check("s3_raddr", 64'(raddr3), 64'h20);
        @(negedge clk);
        check("s3_resp_valid", 64'(rv3), 64'd2);
        check("s3_resp_rdata", 64'(rd3), 64'h1234);
        @(posedge clk); #1;
        v3 = 3'b011; w3 = 3'b001;
        a3[31:0] = 32'h28; d3[31:0] = 32'h5; a3[63:32] = 32'h24;
        @(negedge clk);
        check("s3_wrap_ready", 64'(rdy3), 64'd1);
        @(posedge clk); #1;
        v3 = 3'b000;
        @(negedge clk);
        check("s3_wen", 64'(wen3), 64'd1);
        check("s3_waddr", 64'(waddr3), 64'h28);
        check("s3_wdata", 64'(wdata3), 64'h5);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrlbus_arbiter.md
# ctrlbus_arbiter

Shares one emulator control bus (wen/waddr/wdata, ren/raddr/rdata, single-cycle, no back-pressure) between several requesters, e.g. host MMIO frontend and on-chip scan/checkpoint engine. Each requester issues one read or write through a valid/ready request channel and gets one response on a valid/ready response channel. The output sits directly in front of the control-bus address decoder.

## Interface
- `ADDR_WIDTH`, 32, control-bus address width
- `DATA_WIDTH`, 32, control-bus data width
- `S_COUNT`, 2, number of requesters (≥1)

- `clk`  in  1  clock; all logic on rising edge
- `resetn`  in  1  reset, asynchronous and active-low; one clock domain
- `s_req_valid`  in  S_COUNT  request pending, per requester
- `s_req_ready`  out  S_COUNT  request accepted this cycle
- `s_req_write`  in  S_COUNT  1 = write, 0 = read
- `s_req_addr`  in  S_COUNT*ADDR_WIDTH  address, slice i for requester i
- `s_req_wdata`  in  S_COUNT*DATA_WIDTH  write data
- `s_resp_valid`  out  S_COUNT  response available
- `s_resp_ready`  in  S_COUNT  response consumed
- `s_resp_rdata`  out  DATA_WIDTH  read data, shared by all requesters, qualified by `s_resp_valid[i]`
- `m_ctrl_wen`  out  1  control-bus write strobe
- `m_ctrl_waddr`  out  ADDR_WIDTH  write address
- `m_ctrl_wdata`  out  DATA_WIDTH  write data
- `m_ctrl_ren`  out  1  control-bus read strobe
- `m_ctrl_raddr`  out  ADDR_WIDTH  read address
- `m_ctrl_rdata`  in  DATA_WIDTH  read data, combinationally valid in the cycle `m_ctrl_ren`=1

## Operation
- FSM states: IDLE, ISSUE, RESP. Owner register `own` (clog2(S_COUNT) bits, min 1), priority pointer `ptr`.
- IDLE: the winner is the first `s_req_valid` index at or after `ptr`, searching modulo S_COUNT. `s_req_ready[winner]`=1 combinationally, only in IDLE, only for the winner. On that edge, latch write, addr and wdata, set `own`=winner, go to ISSUE. If no valid request, stay in IDLE.
- ISSUE: for exactly one cycle, drive `m_ctrl_wen` or `m_ctrl_ren` (never both) from the latched registers. On a read, capture `m_ctrl_rdata` into the response register at the end of the cycle. On a write, the response register is 0. Go to RESP.
- RESP: `s_resp_valid[own]`=1. `s_resp_rdata` = response register. On `s_resp_ready[own]`=1, go to IDLE and set `ptr`=(own+1) mod S_COUNT. `s_resp_ready` of non-owners is ignored.
- Address/data outputs are registered and hold their last value outside ISSUE. Strobes are 0 outside ISSUE.
- Requesters must hold their request fields stable while valid and not ready. Deasserting valid before acceptance withdraws the request.
- Only one transaction is outstanding at a time, so the bus never sees concurrent read and write.

## Timing
- Reset values: state IDLE, `ptr`=0, `own`=0, all strobes 0, `s_req_ready`=0 while in reset, `s_resp_valid`=0, addresses, wdata and rdata 0.
- Accept edge at cycle T. Bus strobe in cycle T+1. `s_resp_valid` in cycle T+2.
- With `s_resp_ready` held high, one transaction completes every 3 cycles. Next accept is earliest at T+3.
- Reset asserted mid-transaction: the transaction is dropped with no response; the bus strobe is deasserted immediately (asynchronous).
- S_COUNT=1: `ptr` is constant 0, and arbitration degenerates to pass-through with the same latency.

## Configuration
- `CTRLBUS_ARB_RR_EN` defined: round-robin; `ptr` updates on response completion as above.
- Undefined: fixed priority; `ptr` is held at 0, so the lowest index always wins and starvation is allowed.

## Test plan
- Single write: req0 write addr 0x10 data 0xA5A5 accepted at T -> `m_ctrl_wen`=1, waddr 0x10, wdata 0xA5A5 at T+1 only; `s_resp_valid[0]` at T+2 with rdata 0.
- Single read: req1 read addr 0x20, bus model returns 0x1234 when ren -> `m_ctrl_ren` at T+1, `s_resp_rdata`=0x1234 with `s_resp_valid[1]` at T+2.
- Contention, RR_EN defined, S_COUNT=2: both valid continuously -> grants alternate 0,1,0,1; without the macro -> all grants go to 0.
- Response back-pressure: `s_resp_ready` low for 5 cycles -> `s_resp_valid` and rdata held, no new `s_req_ready`, no bus strobe until ready.
- Reset mid-ISSUE: drop `resetn` during the strobe cycle -> strobes, `s_resp_valid`, `ptr` all 0 immediately; after release the next request proceeds normally.
- S_COUNT=3 with `ptr`=2: only req0 and req1 valid -> req0 granted (wrap-around).
